v_mux_arb: RTL and testbench
============================

# v_mux_arb

Two-requester arbiter that owns the shared 2:1 selection path (A/B inputs, Sel control, Sal output). It grants the path to one requester at a time under round-robin priority and drives Sel from the grant. It registers the selected data onto Sal with a valid strobe. It sits directly in front of the 2:1 mux datapath and replaces the free-running Sel stimulus with a sequenced, handshaken controller.

## Interface
Parameters:
- W, 1, data width of A, B and Sal.
- HOLD_MAX, 8, maximum grant length in cycles before forced hand-over when the other side is waiting; legal range ≥ 2.

Ports:
- Clk  in  1  single clock; all state changes on its rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Req_A  in  1  requester A wants the path; held high for the duration of use.
- A  in  W  requester A data.
- Req_B  in  1  requester B wants the path.
- B  in  W  requester B data.
- Gnt_A  out  1  path granted to A (registered).
- Gnt_B  out  1  path granted to B (registered).
- Sel  out  1  mux select: 0 = A, 1 = B (registered).
- Sal  out  W  registered selected data.
- Val  out  1  Sal carries fresh data this cycle.

## Operation
- FSM states: IDLE, GNT_A, GNT_B. Gnt_A=1 only in GNT_A, Gnt_B=1 only in GNT_B, never both.
- Last-served flag `Last` (0 = A, 1 = B) updates on every entry into a grant state.
- IDLE: only Req_A → GNT_A; only Req_B → GNT_B; both → the side not equal to Last; neither → stay.
- GNT_X with Req_X high: stay, subject to the timeout rule.
- GNT_X with Req_X low: other side requesting → GNT_other on the same edge, with no IDLE bubble; else → IDLE.
- Sel = 0 in GNT_A, 1 in GNT_B. Sel holds its last value in IDLE.
- Data path: Val <= (Gnt_A & Req_A) | (Gnt_B & Req_B). When that term is 1, Sal <= (Sel ? B : A); otherwise Sal holds.
- Hold counter: width $clog2(HOLD_MAX).
  - Clears on every grant-state entry and in IDLE.
  - Increments each cycle in a grant state and saturates at HOLD_MAX-1.

## Timing
- Reset values: state IDLE, Gnt_A=0, Gnt_B=0, Sel=0, Sal=0, Val=0, Last=1 (A wins the first tie), counter=0. Reset takes effect immediately and asynchronously.
- Reset asserted mid-grant: all outputs drop to their reset values immediately. No Val is emitted for the interrupted transfer.
- Latency from IDLE: Req_X rises before edge n → Gnt_X/Sel valid after edge n → first Val/Sal after edge n+1.
- Hand-over: Req_A drops with Req_B high before edge n → Gnt_A=0, Gnt_B=1, Sel=1 after edge n → Val with B data after edge n+1. During edge n, Val=0 because Req_A was low.
- Simultaneous rise of both requests in IDLE: winner is !Last; loser waits and is served next.
- A requester must keep Req high until Gnt arrives. Dropping Req before its grant simply removes the request, with no error.

## Configuration
- Macro: V_MUX_ARB_TIMEOUT_EN.
- Defined:
  - In GNT_X, when counter == HOLD_MAX-1 and Req_other=1, the next edge forces GNT_other even if Req_X is still high.
  - Gnt_X then drops without a handshake.
  - If the other side is idle, the grant continues indefinitely with the counter saturated.
- Undefined: counter logic is absent and grants last until the owner releases Req. HOLD_MAX is ignored.

## Test plan
- Reset: drive Rst_n=0 with random inputs → Gnt_A=Gnt_B=Sel=Val=0 and Sal=0 immediately. Release reset → outputs stay 0 until a request.
- Single requester: W=1, Req_A=1, A toggling 0/1 for 5 cycles → Gnt_A at cycle 1, Val=1 from cycle 2, Sal follows A delayed 1 cycle, Sel=0 throughout.
- Tie and round-robin: Req_A=Req_B=1 from IDLE after reset → A granted first. A releases after 3 cycles → B granted on the next edge with no IDLE cycle and Sel=1.
- B-only transfer: Req_B=1, B=1, Req_A=0 → Gnt_B=1, Sel=1, then Sal=1 with Val=1. Drop Req_B → IDLE and Val=0 next edge.
- Timeout (macro defined, HOLD_MAX=4): A holds Req_A, B raises Req_B → Gnt_A drops after the 4th grant cycle and Gnt_B rises. With the macro undefined, A keeps the grant indefinitely.
- Mid-grant reset: pulse Rst_n low during GNT_B with Val=1 → Gnt_B, Val, Sel and Sal clear asynchronously. After release with both requesting → A granted first, since Last is back at 1.

Source files
------------

// File: rtl/v_mux_arb.sv
// -----------------------------------------------------------------------------
// v_mux_arb
// Two-requester round-robin arbiter in front of a shared 2:1 selection path.
// One requester owns the path at a time; the grant drives the mux select, and
// the selected data is registered onto Sal together with a valid strobe.
//
// Configuration macro: V_MUX_ARB_TIMEOUT_EN
//   defined   : a grant held for HOLD_MAX cycles is forcibly handed to the
//               other side when that side is requesting.
//   undefined : no hold counter; a grant lasts until its owner drops Req.
//
// Parameters:
//   W        - data width of A, B and Sal
//   HOLD_MAX - maximum grant length (cycles) before forced hand-over, >= 2
//
// Ports:
//   Clk    in  clock, rising edge
//   Rst_n  in  asynchronous active-low reset
//   Req_A  in  requester A wants the path
//   A      in  requester A data
//   Req_B  in  requester B wants the path
//   B      in  requester B data
//   Gnt_A  out path granted to A (registered)
//   Gnt_B  out path granted to B (registered)
//   Sel    out mux select, 0 = A, 1 = B (registered)
//   Sal    out registered selected data
//   Val    out Sal carries fresh data this cycle (registered)
// -----------------------------------------------------------------------------
module v_mux_arb #(
   parameter int W        = 1,
   parameter int HOLD_MAX = 8
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         Req_A,
   input  logic [W-1:0] A,
   input  logic         Req_B,
   input  logic [W-1:0] B,
   output logic         Gnt_A,
   output logic         Gnt_B,
   output logic         Sel,
   output logic [W-1:0] Sal,
   output logic         Val
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_A = 2'd1,
      ST_GNT_B = 2'd2
   } state_t;

   // Reject an illegal hold length at elaboration time.
   generate
      if (HOLD_MAX < 2) begin : g_hold_chk
         $error("v_mux_arb: HOLD_MAX must be at least 2");
      end
   endgenerate

   state_t         state_q, state_d;
   logic           last_q, last_d;     // last served side: 0 = A, 1 = B
   logic           gnt_a_q, gnt_a_d;
   logic           gnt_b_q, gnt_b_d;
   logic           sel_q, sel_d;
   logic [W-1:0]   sal_q, sal_d;
   logic           val_q, val_d;
   logic           enter_s;            // a grant state is entered on this edge

`ifdef V_MUX_ARB_TIMEOUT_EN
   localparam int            CW      = $clog2(HOLD_MAX);
   localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          expire_s;            // owner has used its full time slice

   // Slice expiry flag used by the next-state logic.
   always_comb begin
      expire_s = (cnt_q == CNT_MAX);
   end
`endif

   // Next-state decision: round-robin on ties, no idle bubble on hand-over.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (Req_A && Req_B) begin
               state_d = last_q ? ST_GNT_A : ST_GNT_B;
            end else if (Req_A) begin
               state_d = ST_GNT_A;
            end else if (Req_B) begin
               state_d = ST_GNT_B;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GNT_A: begin
            if (Req_A) begin
`ifdef V_MUX_ARB_TIMEOUT_EN
               if (expire_s && Req_B) begin
                  state_d = ST_GNT_B;
               end else begin
                  state_d = ST_GNT_A;
               end
`else
               state_d = ST_GNT_A;
`endif
            end else if (Req_B) begin
               state_d = ST_GNT_B;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GNT_B: begin
            if (Req_B) begin
`ifdef V_MUX_ARB_TIMEOUT_EN
               if (expire_s && Req_A) begin
                  state_d = ST_GNT_A;
               end else begin
                  state_d = ST_GNT_B;
               end
`else
               state_d = ST_GNT_B;
`endif
            end else if (Req_A) begin
               state_d = ST_GNT_A;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Derived next values: grants, select, last-served flag and data path.
   always_comb begin
      enter_s = (state_d != state_q) && (state_d != ST_IDLE);
      gnt_a_d = (state_d == ST_GNT_A);
      gnt_b_d = (state_d == ST_GNT_B);

      sel_d = sel_q;
      if (state_d == ST_GNT_A) begin
         sel_d = 1'b0;
      end else if (state_d == ST_GNT_B) begin
         sel_d = 1'b1;
      end else begin
         sel_d = sel_q;               // select parks on its last value in IDLE
      end

      last_d = last_q;
      if (enter_s) begin
         last_d = (state_d == ST_GNT_B);
      end else begin
         last_d = last_q;
      end

      // Data is valid only while the current owner still holds its request,
      // so the cycle in which the owner releases produces no strobe.
      val_d = (gnt_a_q & Req_A) | (gnt_b_q & Req_B);
      sal_d = sal_q;
      if (val_d) begin
         sal_d = sel_q ? B : A;
      end else begin
         sal_d = sal_q;
      end
   end

`ifdef V_MUX_ARB_TIMEOUT_EN
   // Hold counter: restarts on every grant entry, saturates at the slice end.
   always_comb begin
      cnt_d = cnt_q;
      if ((state_d == ST_IDLE) || enter_s) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Hold counter register.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // State and output registers; reset leaves A as the tie winner.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         sel_q   <= 1'b0;
         sal_q   <= {W{1'b0}};
         val_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
         sel_q   <= sel_d;
         sal_q   <= sal_d;
         val_q   <= val_d;
      end
   end

   assign Gnt_A = gnt_a_q;
   assign Gnt_B = gnt_b_q;
   assign Sel   = sel_q;
   assign Sal   = sal_q;
   assign Val   = val_q;

endmodule

// File: tb/tb_v_mux_arb.sv
// -----------------------------------------------------------------------------
// tb_v_mux_arb
// Directed bench for v_mux_arb (W=4, HOLD_MAX=4). A table of per-cycle
// {inputs, expected outputs} records drives the main scenarios; hand-written
// sequences cover reset behaviour, slice expiry and reset during a grant.
// Output bundle compared everywhere: {Gnt_A, Gnt_B, Sel, Val, Sal}.
// -----------------------------------------------------------------------------
module tb_v_mux_arb;

   localparam int W  = 4;
   localparam int HM = 4;
   localparam int OW = W + 4;

   logic         clk;
   logic         rst_n;
   logic         req_a;
   logic [W-1:0] a;
   logic         req_b;
   logic [W-1:0] b;
   logic         gnt_a;
   logic         gnt_b;
   logic         sel;
   logic [W-1:0] sal;
   logic         val;

   int errors;
   int checks;

   typedef struct {
      string        nm;
      logic         ra;
      logic [W-1:0] da;
      logic         rb;
      logic [W-1:0] db;
      logic [OW-1:0] exp;
   } vec_t;

   vec_t vq[$];

   v_mux_arb #(.W(W), .HOLD_MAX(HM)) dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .Req_A (req_a),
      .A     (a),
      .Req_B (req_b),
      .B     (b),
      .Gnt_A (gnt_a),
      .Gnt_B (gnt_b),
      .Sel   (sel),
      .Sal   (sal),
      .Val   (val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [OW-1:0] exp);
      logic [OW-1:0] got;
      got = {gnt_a, gnt_b, sel, val, sal};
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got {ga,gb,sel,val,sal}=%b required=%b", nm, got, exp);
      end
   endtask

   task automatic add(input string nm, input logic ra, input logic [W-1:0] da,
                      input logic rb, input logic [W-1:0] db,
                      input logic ga, input logic gb, input logic s,
                      input logic v, input logic [W-1:0] d);
      vec_t t;
      t.nm = nm; t.ra = ra; t.da = da; t.rb = rb; t.db = db;
      t.exp = {ga, gb, s, v, d};
      vq.push_back(t);
   endtask

   task automatic drive_cycle(input logic ra, input logic [W-1:0] da,
                              input logic rb, input logic [W-1:0] db);
      @(negedge clk);
      req_a = ra; a = da; req_b = rb; b = db;
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b1;
      req_a = 1'b0; a = 4'd0; req_b = 1'b0; b = 4'd0;

      // ---------------- reset with random inputs ----------------
      #1;
      rst_n = 1'b0;
      req_a = 1'($urandom); a = W'($urandom); req_b = 1'($urandom); b = W'($urandom);
      #1;
      chk("reset_immediate", 8'h00);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         req_a = 1'($urandom); a = W'($urandom); req_b = 1'($urandom); b = W'($urandom);
         @(posedge clk);
         #1;
         chk("reset_held", 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b1;
      req_a = 1'b0; req_b = 1'b0;

      // ---------------- table-driven main scenarios ----------------
      //   name          rA  A     rB  B      gA gB sel val sal
      add("idle0",       0, 4'd3, 0, 4'd5,   0, 0, 0, 0, 4'd0);
      add("idle1",       0, 4'd3, 0, 4'd5,   0, 0, 0, 0, 4'd0);
      add("a_grant",     1, 4'd1, 0, 4'd5,   1, 0, 0, 0, 4'd0);
      add("a_data2",     1, 4'd2, 0, 4'd5,   1, 0, 0, 1, 4'd2);
      add("a_data7",     1, 4'd7, 0, 4'd5,   1, 0, 0, 1, 4'd7);
      add("a_data0",     1, 4'd0, 0, 4'd5,   1, 0, 0, 1, 4'd0);
      add("a_data9",     1, 4'd9, 0, 4'd5,   1, 0, 0, 1, 4'd9);
      add("a_release",   0, 4'd4, 0, 4'd5,   0, 0, 0, 0, 4'd9);
      add("b_grant",     0, 4'd4, 1, 4'd1,   0, 1, 1, 0, 4'd9);
      add("b_data1",     0, 4'd4, 1, 4'd1,   0, 1, 1, 1, 4'd1);
      add("b_data6",     0, 4'd4, 1, 4'd6,   0, 1, 1, 1, 4'd6);
      add("b_release",   0, 4'd4, 0, 4'd2,   0, 0, 1, 0, 4'd6);
      add("idle_selhold",0, 4'd4, 0, 4'd2,   0, 0, 1, 0, 4'd6);
      add("tie_a_wins",  1, 4'd3, 1, 4'd12,  1, 0, 0, 0, 4'd6);
      add("tie_a_d3",    1, 4'd3, 1, 4'd12,  1, 0, 0, 1, 4'd3);
      add("tie_a_d5",    1, 4'd5, 1, 4'd12,  1, 0, 0, 1, 4'd5);
      add("handover_b",  0, 4'd8, 1, 4'd12,  0, 1, 1, 0, 4'd5);
      add("ho_b_d12",    0, 4'd8, 1, 4'd12,  0, 1, 1, 1, 4'd12);
      add("b_hold_bothq",1, 4'd10,1, 4'd11,  0, 1, 1, 1, 4'd11);
      add("handover_a",  1, 4'd10,0, 4'd13,  1, 0, 0, 0, 4'd11);
      add("ho_a_d10",    1, 4'd10,0, 4'd13,  1, 0, 0, 1, 4'd10);
      add("a_release2",  0, 4'd10,0, 4'd13,  0, 0, 0, 0, 4'd10);
      add("tie_b_wins",  1, 4'd1, 1, 4'd2,   0, 1, 1, 0, 4'd10);
      add("tie_b_d2",    1, 4'd1, 1, 4'd2,   0, 1, 1, 1, 4'd2);
      add("handover_a2", 1, 4'd1, 0, 4'd2,   1, 0, 0, 0, 4'd2);
      add("a_release3",  0, 4'd1, 0, 4'd2,   0, 0, 0, 0, 4'd2);

      foreach (vq[i]) begin
         drive_cycle(vq[i].ra, vq[i].da, vq[i].rb, vq[i].db);
         chk(vq[i].nm, vq[i].exp);
      end

      // ---------------- slice expiry: A holds, B waits ----------------
      drive_cycle(1'b1, 4'd5, 1'b0, 4'd6);
      chk("to_a_grant", {1'b1, 1'b0, 1'b0, 1'b0, 4'd2});
      for (int i = 1; i <= 6; i++) begin
         logic [OW-1:0] e;
         drive_cycle(1'b1, 4'd5, 1'b1, 4'd6);
`ifdef V_MUX_ARB_TIMEOUT_EN
         if (i < HM)       e = {1'b1, 1'b0, 1'b0, 1'b1, 4'd5};
         else if (i == HM) e = {1'b0, 1'b1, 1'b1, 1'b1, 4'd5};
         else              e = {1'b0, 1'b1, 1'b1, 1'b1, 4'd6};
`else
         e = {1'b1, 1'b0, 1'b0, 1'b1, 4'd5};
`endif
         chk($sformatf("to_cycle%0d", i), e);
      end
      drive_cycle(1'b0, 4'd5, 1'b0, 4'd6);
`ifdef V_MUX_ARB_TIMEOUT_EN
      chk("to_release", {1'b0, 1'b0, 1'b1, 1'b0, 4'd6});
`else
      chk("to_release", {1'b0, 1'b0, 1'b0, 1'b0, 4'd5});
`endif

      // ---------------- reset during an active B grant ----------------
      drive_cycle(1'b0, 4'd3, 1'b1, 4'd9);
`ifdef V_MUX_ARB_TIMEOUT_EN
      chk("mr_b_grant", {1'b0, 1'b1, 1'b1, 1'b0, 4'd6});
`else
      chk("mr_b_grant", {1'b0, 1'b1, 1'b1, 1'b0, 4'd5});
`endif
      drive_cycle(1'b0, 4'd3, 1'b1, 4'd9);
      chk("mr_b_data", {1'b0, 1'b1, 1'b1, 1'b1, 4'd9});
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_async_clear", 8'h00);
      @(negedge clk);
      req_a = 1'($urandom); a = W'($urandom); req_b = 1'($urandom); b = W'($urandom);
      @(posedge clk);
      #1;
      chk("mr_held", 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      req_a = 1'b1; a = 4'd4; req_b = 1'b1; b = 4'd7;
      @(posedge clk);
      #1;
      chk("mr_tie_a_first", {1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
      drive_cycle(1'b1, 4'd4, 1'b1, 4'd7);
      chk("mr_a_data", {1'b1, 1'b0, 1'b0, 1'b1, 4'd4});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
